// File: rtl/debounce_edge.sv
// debounce_edge: synchronize and debounce a raw input, expose level/prev, rise/fall strobes and a rise counter
module debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr,
    output logic             level,
    output logic             prev,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] count
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             level_q, level_d;
    logic             prev_q, s1_q, s2_q;
    logic [CNT_W-1:0] count_q;

    // two-flop synchronizer; only s2 is consumed downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    // debounce state, counter and level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            dcnt_q  <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
        end
    end

    // next state: level flips only after N consecutive disagreeing samples
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        level_d = level_q;
        unique case (state_q)
            STABLE_LO: if (s2_q) begin
                dcnt_d = DW'(1);
                if (DEBOUNCE_CYCLES == 1) begin
                    level_d = 1'b1;
                    state_d = STABLE_HI;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: if (!s2_q) begin
                dcnt_d  = '0;
                state_d = STABLE_LO;
            end else if (dcnt_q == LAST) begin
                level_d = 1'b1;
                dcnt_d  = '0;
                state_d = STABLE_HI;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
            STABLE_HI: if (!s2_q) begin
                dcnt_d = DW'(1);
                if (DEBOUNCE_CYCLES == 1) begin
                    level_d = 1'b0;
                    state_d = STABLE_LO;
                end else begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: if (s2_q) begin
                dcnt_d  = '0;
                state_d = STABLE_HI;
            end else if (dcnt_q == LAST) begin
                level_d = 1'b0;
                dcnt_d  = '0;
                state_d = STABLE_LO;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        endcase
    end

    // delayed level and rise counter; clear beats a simultaneous rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            prev_q  <= level_q;
            count_q <= clr ? '0 : rise ? count_q + CNT_W'(1) : count_q;
        end
    end

    assign level = level_q;
    assign prev  = prev_q;
    assign rise  = level_q & ~prev_q;
    assign fall  = ~level_q & prev_q;
    assign count = count_q;
endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: directed checks of debounce latency, glitch rejection, strobes, counter wrap/clear and reset
module tb_debounce_edge;
    logic       clk = 1'b0;
    logic       rst_n, din, clr;
    logic       level, prev, rise, fall;
    logic [1:0] count;
    logic       level1, prev1, rise1, fall1;
    logic [7:0] count1;
    int         n_cmp = 0;
    int         n_bad = 0;

    debounce_edge #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
        .level(level), .prev(prev), .rise(rise), .fall(fall), .count(count)
    );

    debounce_edge #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
        .level(level1), .prev(prev1), .rise(rise1), .fall(fall1), .count(count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b1;
        clr   = 1'b0;
        #2;
        repeat (10) begin
            tick();
            chk("rst_level", level, 0);
            chk("rst_prev", prev, 0);
            chk("rst_rise", rise, 0);
            chk("rst_fall", fall, 0);
            chk("rst_count", count, 0);
        end
        rst_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk("rise_level", level, e >= 5);
            chk("rise_strobe", rise, e == 5);
            chk("rise_prev", prev, e >= 6);
            chk("rise_count", count, (e >= 6) ? 1 : 0);
            chk("n1_level", level1, e >= 2);
            chk("n1_rise", rise1, e == 2);
        end
        din = 1'b0;
        for (int e = 9; e <= 16; e++) begin
            tick();
            chk("fall_strobe", fall, e == 14);
            chk("fall_level", level, e < 14);
            chk("fall_count", count, 1);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_count", count, 0);
        repeat (5) begin
            din = 1'b1;
            repeat (3) begin
                tick();
                chk("glitch_level", level, 0);
                chk("glitch_rise", rise, 0);
            end
            din = 1'b0;
            repeat (5) begin
                tick();
                chk("glitch_level", level, 0);
                chk("glitch_rise", rise, 0);
            end
        end
        chk("glitch_count", count, 0);
        for (int e = 0; e <= 11; e++) begin
            din = (e < 4);
            tick();
            chk("exactn_level", level, (e >= 5) && (e <= 8));
            chk("exactn_rise", rise, e == 5);
            chk("exactn_fall", fall, e == 9);
        end
        chk("exactn_count", count, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            din = 1'b1;
            wait_n(10);
            chk("wrap_count", count, i % 4);
            din = 1'b0;
            wait_n(10);
        end
        din = 1'b1;
        for (int e = 0; e <= 5; e++) tick();
        chk("coll_rise", rise, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("coll_count", count, 0);
        tick();
        chk("coll_count_hold", count, 0);
        chk("coll_rise_gone", rise, 0);
        din = 1'b0;
        wait_n(10);
        din = 1'b1;
        wait_n(7);
        chk("late_count_pre", count, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("late_count_clr", count, 0);
        din = 1'b0;
        wait_n(10);
        din = 1'b1;
        wait_n(10);
        chk("late_count_next", count, 1);
        chk("async_pre_level", level, 1);
        din = 1'b0;
        wait_n(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_level", level, 0);
        chk("async_prev", prev, 0);
        chk("async_count", count, 0);
        chk("async_fall", fall, 0);
        tick();
        rst_n = 1'b1;
        wait_n(10);
        chk("async_settle", level, 0);
        din = 1'b1;
        wait_n(3);
        #2;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk("midrst_level", level, e >= 5);
            chk("midrst_rise", rise, e == 5);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
